// File: rtl/seq_detector.sv
// Serial pattern detector: a KMP automaton built from PATTERN at elaboration,
// with a registered Moore match flag and a saturating match counter.
module seq_detector #(
  parameter int PAT_W   = 4,
  parameter     PATTERN = 4'b1011,
  parameter bit OVERLAP = 1'b1,
  parameter int CNT_W   = 8,
  localparam int SW     = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             x_in,
  input  logic             clear,
  output logic [SW-1:0]    state_out,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow
);

  if (PAT_W < 1 || PAT_W > 16) begin : g_bad_width
    $error("seq_detector: PAT_W must be in 1..16");
  end
  if ((PATTERN >> PAT_W) != 0) begin : g_bad_pattern
    $error("seq_detector: PATTERN is wider than PAT_W bits");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("seq_detector: CNT_W must be at least 1");
  end

  localparam logic [PAT_W-1:0] PAT      = PAT_W'(PATTERN);
  localparam logic [SW-1:0]    FULL     = SW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam int               ENTRIES  = 2 ** (SW + 1);

  // Next state from prefix length k after bit b: the longest suffix of
  // (pattern[0..k-1], b) that is also a pattern prefix. States past PAT_W
  // are unreachable and map to S0.
  function automatic logic [SW-1:0] kmp_next(input int k, input logic b);
    logic [PAT_W:0] s;
    logic           ok;
    int             best;
    s    = '0;
    best = 0;
    if (k > PAT_W) return '0;
    if (k == PAT_W && !OVERLAP) return (b == PAT[PAT_W-1]) ? SW'(1) : '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (i < k) s[i] = PAT[PAT_W-1-i];
    end
    s[k] = b;
    for (int l = 1; l <= PAT_W; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          if (s[k+1-l+j] != PAT[PAT_W-1-j]) ok = 1'b0;
        end
        if (ok) best = l;
      end
    end
    return SW'(best);
  endfunction

  // Transition table indexed by {state, x_in}.
  logic [SW-1:0] next_tab [ENTRIES];
  for (genvar e = 0; e < ENTRIES; e++) begin : g_tab
    assign next_tab[e] = kmp_next(e / 2, 1'(e % 2));
  end

  logic [SW-1:0] state;
  logic [SW-1:0] next_state;

  assign next_state = next_tab[{state, x_in}];
  assign state_out  = state;

  // enable qualifies x_in for one edge; there is no back-pressure.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= '0;
      match       <= 1'b0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (enable) begin
        state <= next_state;
        match <= (next_state == FULL);
      end
      if (clear) begin
        match_count <= '0;
        overflow    <= 1'b0;
      end else if (enable && next_state == FULL) begin
        if (match_count == CNT_MAX) overflow <= 1'b1;
        else match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: five parameterisations share one stimulus stream and
// are compared against a history-based reference model, plus directed cases.
module tb_seq_detector;

  logic clock, reset, enable, x_in, clear;

  logic [2:0] st_a, st_b, st_c, st_e;
  logic [0:0] st_d;
  logic       m_a, m_b, m_c, m_d, m_e;
  logic       o_a, o_b, o_c, o_d, o_e;
  logic [7:0] c_a, c_b;
  logic [1:0] c_c;
  logic [3:0] c_d;
  logic [2:0] c_e;

  seq_detector u_a (.clock(clock), .reset(reset), .enable(enable), .x_in(x_in), .clear(clear),
    .state_out(st_a), .match(m_a), .match_count(c_a), .overflow(o_a));
  seq_detector #(.OVERLAP(1'b0)) u_b (.clock(clock), .reset(reset), .enable(enable), .x_in(x_in),
    .clear(clear), .state_out(st_b), .match(m_b), .match_count(c_b), .overflow(o_b));
  seq_detector #(.CNT_W(2)) u_c (.clock(clock), .reset(reset), .enable(enable), .x_in(x_in),
    .clear(clear), .state_out(st_c), .match(m_c), .match_count(c_c), .overflow(o_c));
  seq_detector #(.PAT_W(1), .PATTERN(1'b1), .CNT_W(4)) u_d (.clock(clock), .reset(reset),
    .enable(enable), .x_in(x_in), .clear(clear), .state_out(st_d), .match(m_d),
    .match_count(c_d), .overflow(o_d));
  seq_detector #(.PAT_W(5), .PATTERN(5'b11011), .CNT_W(3)) u_e (.clock(clock), .reset(reset),
    .enable(enable), .x_in(x_in), .clear(clear), .state_out(st_e), .match(m_e),
    .match_count(c_e), .overflow(o_e));

  logic [31:0] obs_st [5];
  logic [31:0] obs_m  [5];
  logic [31:0] obs_c  [5];
  logic [31:0] obs_o  [5];
  assign obs_st[0] = 32'(st_a); assign obs_m[0] = 32'(m_a); assign obs_c[0] = 32'(c_a); assign obs_o[0] = 32'(o_a);
  assign obs_st[1] = 32'(st_b); assign obs_m[1] = 32'(m_b); assign obs_c[1] = 32'(c_b); assign obs_o[1] = 32'(o_b);
  assign obs_st[2] = 32'(st_c); assign obs_m[2] = 32'(m_c); assign obs_c[2] = 32'(c_c); assign obs_o[2] = 32'(o_c);
  assign obs_st[3] = 32'(st_d); assign obs_m[3] = 32'(m_d); assign obs_c[3] = 32'(c_d); assign obs_o[3] = 32'(o_d);
  assign obs_st[4] = 32'(st_e); assign obs_m[4] = 32'(m_e); assign obs_c[4] = 32'(c_e); assign obs_o[4] = 32'(o_e);

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- checking ----------------
  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else checks_passed++;
  endtask

  // ---------------- reference model ----------------
  // State is the longest suffix of the accepted-bit history that is a pattern
  // prefix; without overlap the history is dropped after each match.
  int          pw   [5] = '{4, 4, 4, 1, 5};
  logic [15:0] pat  [5] = '{16'b1011, 16'b1011, 16'b1011, 16'b1, 16'b11011};
  bit          ovl  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int          cmax [5] = '{255, 255, 3, 15, 7};

  logic [15:0] m_hist [5];
  int          m_len  [5];
  int          m_st   [5];
  int          m_cnt  [5];
  bit          m_ovf  [5];
  bit          m_rst  [5];

  function automatic int longest(input int i);
    int top;
    bit ok;
    top = (m_len[i] < pw[i]) ? m_len[i] : pw[i];
    for (int l = top; l >= 1; l--) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++)
        if (m_hist[i][l-1-j] != pat[i][pw[i]-1-j]) ok = 1'b0;
      if (ok) return l;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_hist[i] = '0; m_len[i] = 0; m_st[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_rst[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit en, input bit x, input bit clr);
    bit hit;
    for (int i = 0; i < 5; i++) begin
      hit = 1'b0;
      if (en) begin
        if (m_rst[i]) begin m_len[i] = 0; m_rst[i] = 1'b0; end
        m_hist[i] = {m_hist[i][14:0], x};
        m_len[i]  = (m_len[i] < 16) ? m_len[i] + 1 : 16;
        m_st[i]   = longest(i);
        hit       = (m_st[i] == pw[i]);
        if (hit && !ovl[i]) m_rst[i] = 1'b1;
      end
      if (clr) begin
        m_cnt[i] = 0; m_ovf[i] = 1'b0;
      end else if (hit) begin
        if (m_cnt[i] == cmax[i]) m_ovf[i] = 1'b1;
        else m_cnt[i]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("inst%0d state", i), obs_st[i], 32'(m_st[i]));
      check($sformatf("inst%0d match", i), obs_m[i], 32'(m_st[i] == pw[i]));
      check($sformatf("inst%0d count", i), obs_c[i], 32'(m_cnt[i]));
      check($sformatf("inst%0d overflow", i), obs_o[i], 32'(m_ovf[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit en, input bit x, input bit clr);
    enable = en; x_in = x; clear = clr;
    @(posedge clock); #1;
    model_step(en, x, clr);
    compare_all();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    model_reset();
    check("async reset state", obs_st[0], 0);
    check("async reset match", obs_m[0], 0);
    check("async reset count", obs_c[0], 0);
    check("async reset overflow", obs_o[0], 0);
    compare_all();
    reset = 1'b1;
    #1;
  endtask

  // ---------------- scoreboard / directed + random ----------------
  logic [31:0] exp_q[$];
  int xs     [7] = '{1, 0, 1, 1, 0, 1, 1};
  int st_ov  [7] = '{1, 2, 3, 4, 2, 3, 4};
  int st_no  [7] = '{1, 2, 3, 4, 0, 1, 1};
  int d_bits [4] = '{1, 1, 0, 1};

  initial begin
    reset = 1'b0; enable = 1'b0; x_in = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    reset = 1'b1;

    // Overlap vs non-overlap on the same stream
    for (int i = 0; i < 7; i++) exp_q.push_back(32'(st_ov[i]));
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'(xs[i]), 1'b0);
      check("overlap state", obs_st[0], exp_q.pop_front());
      check("overlap match", obs_m[0], 32'(st_ov[i] == 4));
      check("no-overlap state", obs_st[1], 32'(st_no[i]));
      check("no-overlap match", obs_m[1], 32'(i == 3));
    end
    check("overlap count", obs_c[0], 2);
    check("no-overlap count", obs_c[1], 1);

    // Async reset from state 3 with two matches
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("pre-reset state", obs_st[0], 3);
    check("pre-reset count", obs_c[0], 2);
    pulse_reset();

    // Enable gating
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'(g % 2), 1'b0);
      check("gated hold state", obs_st[0], 3);
    end
    step(1'b1, 1'b1, 1'b0);
    check("gated resume state", obs_st[0], 4);
    check("gated resume match", obs_m[0], 1);

    // Saturation on the 2-bit counter, then clear against a 5th match
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'(xs[i]), 1'b0);
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    check("sat count", obs_c[2], 3);
    check("sat overflow", obs_o[2], 1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clear count", obs_c[2], 0);
    check("clear overflow", obs_o[2], 0);
    check("clear keeps state", obs_st[2], 4);

    // Single-bit pattern
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'(d_bits[i]), 1'b0);
      check("pat1 match", obs_m[3], 32'(d_bits[i]));
    end
    check("pat1 count", obs_c[3], 3);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
